cpu_term_ctrl: RTL and testbench

- Bus-cycle termination front end for the DMA CPU state machine. Sits directly upstream of the per-bit next-state logic and feeds it the qualified DSACK and STERM_ terms.
- Synchronises the asynchronous 68030 termination inputs (DSACK0_, DSACK1_, BERR_) and samples the synchronous STERM_.
- Tracks each master cycle, applies fixed termination priority and reports port width.
- Generates a bus error on cycle timeout.

---
 rtl/cpu_term_pkg.sv | 23 ++
 rtl/cpu_term_ctrl_if.sv | 24 ++
 rtl/cpu_sync_ff.sv | 21 ++
 rtl/cpu_term_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cpu_term_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/cpu_term_pkg.sv
// Shared types and defaults for the 68030 bus-cycle termination front end.
// State encoding, termination causes and default parameter values.
package cpu_term_pkg;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TERM    = 2'd2,
        ST_RECOVER = 2'd3
    } term_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_BERR    = 3'd1,
        CAUSE_STERM   = 3'd2,
        CAUSE_DSACK   = 3'd3,
        CAUSE_TIMEOUT = 3'd4
    } term_cause_e;

endpackage

// File: rtl/cpu_term_ctrl_if.sv
// Termination bus between the CPU state machine side and cpu_term_ctrl.
// master = CPU/bus side driving raw terms, slave = cpu_term_ctrl.
interface cpu_term_ctrl_if;
    logic CYC_ACTIVE;
    logic DSACK0_;
    logic DSACK1_;
    logic STERM_IN_;
    logic BERR_;
    logic DSACK;
    logic STERM_;
    logic PORT32;
    logic BUS_ERR;
    logic TIMEOUT;

    modport master (
        output CYC_ACTIVE, DSACK0_, DSACK1_, STERM_IN_, BERR_,
        input  DSACK, STERM_, PORT32, BUS_ERR, TIMEOUT
    );

    modport slave (
        input  CYC_ACTIVE, DSACK0_, DSACK1_, STERM_IN_, BERR_,
        output DSACK, STERM_, PORT32, BUS_ERR, TIMEOUT
    );
endinterface

// File: rtl/cpu_sync_ff.sv
// N-stage flop synchroniser for active-low async inputs; resets to 1 (negated).
module cpu_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/cpu_term_ctrl.sv
// Qualifies 68030 termination inputs for the DMA CPU state machine.
// Optional cycle timeout built only when CPU_TERM_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | no master cycle, waiting for CYC_ACTIVE rise
// WAIT       | cycle running, waiting for BERR/STERM/DSACK/timeout
// TERM       | async termination seen, DSACK held until CYC_ACTIVE drops
// RECOVER    | waiting for CYC_ACTIVE and all synced terms to negate
module cpu_term_ctrl
    import cpu_term_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = 8
) (
    input  logic           CLK,
    input  logic           RST,
    cpu_term_ctrl_if.slave bus
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_param
        $error("cpu_term_ctrl: illegal SYNC_STAGES/TIMEOUT_CYCLES/TO_W");
    end

    logic dsack0_s, dsack1_s, berr_s;
    logic sterm_q, cyc_q, berr_s_prev;
    logic to_hit;

    term_state_e state_q, state_nxt;
    term_cause_e cause_q, cause_nxt;
    logic        port32_lat_q, port32_lat_nxt;

    logic dsack_q, sterm_o_q, port32_q, bus_err_q;

    cpu_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dsack0 (
        .CLK(CLK), .RST(RST), .d(bus.DSACK0_), .q(dsack0_s)
    );
    cpu_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dsack1 (
        .CLK(CLK), .RST(RST), .d(bus.DSACK1_), .q(dsack1_s)
    );
    cpu_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_berr (
        .CLK(CLK), .RST(RST), .d(bus.BERR_), .q(berr_s)
    );

    // STERM_ is already synchronous to CLK, so one register is enough.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sterm_q     <= 1'b1;
            cyc_q       <= 1'b0;
            berr_s_prev <= 1'b1;
        end else begin
            sterm_q     <= bus.STERM_IN_;
            cyc_q       <= bus.CYC_ACTIVE;
            berr_s_prev <= berr_s;
        end
    end

`ifdef CPU_TERM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_nxt;
    logic            timeout_q;

    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Counter only advances in WAIT and is zero on every entry into WAIT.
    always_comb begin
        to_cnt_nxt = '0;
        if (state_q == ST_WAIT) begin
            to_cnt_nxt = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_nxt;
            timeout_q <= (cause_q == CAUSE_TIMEOUT);
        end
    end

    assign bus.TIMEOUT = timeout_q;
`else
    assign to_hit      = 1'b0;
    assign bus.TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cause_q      <= CAUSE_NONE;
            port32_lat_q <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cause_q      <= cause_nxt;
            port32_lat_q <= port32_lat_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        cause_nxt      = CAUSE_NONE;
        port32_lat_nxt = port32_lat_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.CYC_ACTIVE && !cyc_q) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.CYC_ACTIVE) begin
                    state_nxt = ST_IDLE;
                end else if (!berr_s) begin
                    state_nxt = ST_RECOVER;
                    cause_nxt = CAUSE_BERR;
                end else if (!sterm_q) begin
                    state_nxt = ST_RECOVER;
                    cause_nxt = CAUSE_STERM;
                end else if (!dsack0_s || !dsack1_s) begin
                    state_nxt      = ST_TERM;
                    cause_nxt      = CAUSE_DSACK;
                    port32_lat_nxt = !dsack0_s && !dsack1_s;
                end else if (to_hit) begin
                    state_nxt = ST_RECOVER;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_TERM: begin
                if (!bus.CYC_ACTIVE) begin
                    state_nxt = ST_RECOVER;
                end
                // Late BERR after DSACK: report once on its falling edge.
                if (!berr_s && berr_s_prev) begin
                    cause_nxt = CAUSE_BERR;
                end
            end
            ST_RECOVER: begin
                if (!bus.CYC_ACTIVE && dsack0_s && dsack1_s && berr_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dsack_q   <= 1'b0;
            sterm_o_q <= 1'b1;
            port32_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            dsack_q   <= (state_q == ST_TERM);
            sterm_o_q <= (cause_q != CAUSE_STERM);
            port32_q  <= (state_q == ST_TERM) && port32_lat_q;
            bus_err_q <= (cause_q == CAUSE_BERR) || (cause_q == CAUSE_TIMEOUT);
        end
    end

    assign bus.DSACK   = dsack_q;
    assign bus.STERM_  = sterm_o_q;
    assign bus.PORT32  = port32_q;
    assign bus.BUS_ERR = bus_err_q;
endmodule

// File: tb/tb_cpu_term_ctrl.sv
// Self-checking bench for cpu_term_ctrl: directed steps plus random cycles
// checked against an event-time model of the termination rules.
module tb_cpu_term_ctrl;
    localparam int S     = 2;
`ifdef CPU_TERM_TIMEOUT_EN
    localparam int TC    = 16;
    localparam bit TO_ON = 1'b1;
`else
    localparam int TC    = 255;
    localparam bit TO_ON = 1'b0;
`endif
    localparam int NEVER = 100000;
    localparam int R     = 2;
    localparam logic [4:0] IDLE_OUT = 5'b01000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [4:0] obs;
    int n_tests = 0;
    int n_fail  = 0;

    cpu_term_ctrl_if bus();

    cpu_term_ctrl #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TC), .TO_W(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // {DSACK, STERM_, PORT32, BUS_ERR, TIMEOUT}
    assign obs = {bus.DSACK, bus.STERM_, bus.PORT32, bus.BUS_ERR, bus.TIMEOUT};

    task automatic check(input string tag, input int c, input logic [4:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc %0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.CYC_ACTIVE = 1'b0;
        bus.DSACK0_    = 1'b1;
        bus.DSACK1_    = 1'b1;
        bus.STERM_IN_  = 1'b1;
        bus.BERR_      = 1'b1;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            @(posedge CLK); #1;
            check(tag, c, IDLE_OUT);
        end
    endtask

    // One master cycle: CYC_ACTIVE high over edges [R, tf); each raw term is
    // low from its edge until tf. Outputs are predicted from decision edges.
    task automatic run_scenario(input string tag, input int tb_, input int ts,
                                input int t0, input int t1, input int tf);
        int d[5];
        int win, dw, dd, bterm, w;
        logic [4:0] exp;
        if (tb_ >= tf) tb_ = NEVER;
        if (ts  >= tf) ts  = NEVER;
        if (t0  >= tf) t0  = NEVER;
        if (t1  >= tf) t1  = NEVER;
        dd    = (t0 < t1) ? t0 : t1;
        d[0]  = tf;
        d[1]  = (tb_ == NEVER) ? NEVER : tb_ + S;
        d[2]  = (ts  == NEVER) ? NEVER : ts + 1;
        d[3]  = (dd  == NEVER) ? NEVER : dd + S;
        d[4]  = TO_ON ? R + TC : NEVER;
        win = 0;
        for (int i = 1; i < 5; i++) if (d[i] < d[win]) win = i;
        dw    = d[win];
        bterm = d[1];
        w     = tf + 10;
        for (int c = 0; c < w; c++) begin
            @(negedge CLK);
            bus.CYC_ACTIVE = (c >= R && c < tf);
            bus.BERR_      = !(c >= tb_ && c < tf);
            bus.STERM_IN_  = !(c >= ts  && c < tf);
            bus.DSACK0_    = !(c >= t0  && c < tf);
            bus.DSACK1_    = !(c >= t1  && c < tf);
            @(posedge CLK); #1;
            exp[4] = (win == 3) && c >= dw + 1 && c <= tf;
            exp[3] = !((win == 2) && c == dw + 1);
            exp[2] = exp[4] && (t0 == t1);
            exp[1] = (((win == 1) || (win == 4)) && c == dw + 1) ||
                     ((win == 3) && bterm > dw && bterm <= tf && c == bterm + 1);
            exp[0] = (win == 4) && c == dw + 1;
            check(tag, c, exp);
        end
        drive_idle();
    endtask

    initial begin
        int tb_, ts, t0, t1, tf;
        bit reached;
        drive_idle();
        bus.DSACK0_ = 1'b0;
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            @(posedge CLK); #1;
            check("reset", c, IDLE_OUT);
        end
        @(negedge CLK);
        RST = 1'b0;
        idle_cycles("reset_release", 3);
        bus.DSACK0_ = 1'b1;
        idle_cycles("reset_settle", 4);

        run_scenario("async32",     NEVER, NEVER, 5,     5,     12);
        run_scenario("async16",     NEVER, NEVER, NEVER, 4,     10);
        run_scenario("dsack_skew",  NEVER, NEVER, 5,     6,     13);
        run_scenario("sterm_prio",  NEVER, 6,     NEVER, 6,     14);
        run_scenario("berr_prio",   6,     NEVER, 6,     NEVER, 14);
        run_scenario("late_berr",   8,     NEVER, 4,     4,     14);
        run_scenario("abort",       NEVER, NEVER, NEVER, NEVER, R + 4);
        run_scenario("timeout",     NEVER, NEVER, NEVER, NEVER, R + 20);
        run_scenario("long_wait",   NEVER, NEVER, NEVER, NEVER, R + 300);

        // Reset while DSACK is held in TERM.
        @(negedge CLK);
        bus.CYC_ACTIVE = 1'b1;
        bus.DSACK0_    = 1'b0;
        bus.DSACK1_    = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            @(posedge CLK); #1;
            if (bus.DSACK === 1'b1) reached = 1'b1;
        end
        n_tests++;
        assert (reached === 1'b1) else begin
            n_fail++;
            $error("FAIL rst_term_reach observed=%b expected=1", reached);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_in_term", 0, IDLE_OUT);
        @(negedge CLK);
        RST = 1'b0;
        drive_idle();
        idle_cycles("rst_term_idle", 4);
        run_scenario("post_rst", NEVER, NEVER, 4, NEVER, 10);

        for (int n = 0; n < 40; n++) begin
            t0 = ($urandom_range(0, 3) == 0) ? NEVER : R + int'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       t1 = t0;
                1:       t1 = (t0 == NEVER) ? NEVER : t0 + 1;
                2:       t1 = NEVER;
                default: t1 = R + int'($urandom_range(0, 15));
            endcase
            tb_ = ($urandom_range(0, 3) == 0) ? R + int'($urandom_range(0, 20)) : NEVER;
            ts  = ($urandom_range(0, 3) == 0) ? R + int'($urandom_range(0, 20)) : NEVER;
            tf  = R + int'($urandom_range(1, 28));
            run_scenario("random", tb_, ts, t0, t1, tf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
